isqrt_iter: RTL
===============

# isqrt_iter

Iterative unsigned integer square root unit. It is the responder side of the `isqrt` request/response interface used by the formula FSMs: `x_vld`/`x` go in, `y_vld`/`y` come out. It computes floor(sqrt(x)) of a 32-bit operand with a restoring digit-by-digit algorithm, one result bit per clock. It replaces a pipelined isqrt wherever area matters more than throughput, and it can be dropped directly into the distributor's per-instance isqrt sockets.

## Interface

Parameters:
- none; all widths are fixed by the isqrt interface.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `x_vld`  input  1  request strobe, one cycle per request.
- `x`  input  32  unsigned radicand, sampled only when the request is accepted.
- `y_vld`  output  1  result strobe, exactly one cycle per accepted request.
- `y`  output  16  floor(sqrt(x)); holds its value until the next result.
- `busy`  output  1  high while a computation is in progress; requests seen while high are not started.

## Operation

- States, from the shared enum:
  - `ST_IDLE`: no computation.
  - `ST_CALC`: 16 iterations, tracked by a 4-bit counter `iter` running 15 down to 0.
  - `ST_DONE`: 1 cycle; `y_vld` is high.
- Transitions:
  - `ST_IDLE` → `ST_CALC` on `x_vld`.
  - `ST_CALC` → `ST_DONE` when `iter == 0`.
  - `ST_DONE` → `ST_CALC` if a request is available (see below), otherwise `ST_DONE` → `ST_IDLE`.
- Start: load `rad <= x`, `rem <= 0`, `root <= 0`, `iter <= 15`.
- Each `ST_CALC` cycle, with `rem` 18 bits and `root` 16 bits:
  - `r2 = {rem[15:0], rad[31:30]}`
  - `t = {root, 2'b01}`, zero-extended to 18 bits
  - if `r2 >= t`: `rem <= r2 - t`, `root <= {root[14:0], 1}`
  - else: `rem <= r2`, `root <= {root[14:0], 0}`
  - `rad <= rad << 2`
- On the last iteration, `y` is registered with the final root value.
- `busy` = (`state == ST_CALC`). `ST_DONE` accepts a new `x_vld` directly, so back-to-back operation needs no idle cycle.
- Request arriving while `busy`: handled as described under Configuration.
- Reset values: `y_vld` = 0, `y` = 0, `busy` = 0, state = `ST_IDLE`, `iter` = 0, pending buffer empty.
- Reset mid-operation: the computation is abandoned and no `y_vld` is produced for it. After reset release, the first `x_vld` starts a fresh computation.

## Timing

- Latency: `x_vld` high in cycle T (accepted at the edge ending T) gives `y_vld` high in cycle T+17, for exactly one cycle.
- `busy` is high in cycles T+1 through T+16.
- Maximum throughput: one result per 17 cycles.
- `y` is valid from cycle T+17 and is stable until the next `y_vld`.
- There is no combinational path from input to output; all outputs are registered.

## Configuration

- `ISQRT_ITER_PENDING_EN` defined:
  - A one-entry pending buffer (`pend_vld`, `pend_x`) captures the first `x_vld` that arrives while `busy`.
  - In `ST_DONE` with `pend_vld` set, the buffered request starts at that edge, giving `y_vld` 17 cycles later.
  - If `x_vld` is high in the same `ST_DONE` cycle, that request is written into the pending buffer as it is vacated.
  - Further requests while the buffer is full are dropped.
- `ISQRT_ITER_PENDING_EN` undefined: every `x_vld` seen while `busy` is ignored; no `y_vld` is ever produced for it.

## Structure

- Package `isqrt_iter_pkg` holds:
  - `state_t` enum (`ST_IDLE`, `ST_CALC`, `ST_DONE`)
  - `ISQRT_ITERS = 16`
  - `ISQRT_X_W = 32`
  - `ISQRT_Y_W = 16`
- Sub-module `isqrt_iter_step` is purely combinational. It takes `rem`, `root`, and `rad[31:30]` and returns the next `rem`/`root`. The top-level block owns the FSM, the counter, the registers, and the pending buffer.

## Test plan

- Basic results:
  - `x=0` at T → `y_vld` at T+17, `y=0`.
  - `x=16` → `y=4`.
  - `x=15` → `y=3`.
- Extremes:
  - `x=32'hFFFF_FFFF` → `y=16'hFFFF`.
  - `x=32'hFFFE_0001` → `y=16'hFFFF`.
  - `x=32'hFFFE_0000` → `y=16'hFFFE`.
- Back-to-back:
  - `x=100` at T, `x=49` at T+17 (the `ST_DONE` cycle) → `y=10` at T+17, `y=7` at T+34.
- Overlap:
  - `x=100` at T, `x=49` at T+5.
  - Without the macro: only `y=10` at T+17, and no second `y_vld`.
  - With the macro: `y=7` at T+34.
  - Adding a third request `x=9` at T+6 with the macro: dropped, no third `y_vld`.
- Reset mid-operation:
  - `x=1000` at T, `rst` low during T+8.
  - No `y_vld` at T+17; `y=0`, `busy=0` after reset.
  - `x=1000` after release → `y=31` 17 cycles later.
- Random: 10k random `x` values compared against a floor(sqrt) reference model, checking that exactly one `y_vld` is produced per accepted request.

Source files
------------

// File: rtl/isqrt_iter_pkg.sv
// isqrt_iter_pkg: shared types and widths for the iterative isqrt unit.
//   state_t      : controller states (idle / iterating / result strobe)
//   ISQRT_ITERS  : iterations per result, one root bit each
//   ISQRT_X_W    : radicand width
//   ISQRT_Y_W    : root width
package isqrt_iter_pkg;

  localparam int unsigned ISQRT_ITERS = 16;
  localparam int unsigned ISQRT_X_W   = 32;
  localparam int unsigned ISQRT_Y_W   = 16;
  localparam int unsigned ISQRT_REM_W = ISQRT_Y_W + 2;
  localparam int unsigned ISQRT_CNT_W = $clog2(ISQRT_ITERS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/isqrt_iter_step.sv
// isqrt_iter_step: one restoring digit-by-digit square-root iteration.
// Purely combinational.
//   rem      in  : partial remainder
//   root     in  : partial root
//   rad_top  in  : next two radicand bits (rad[31:30])
//   rem_nxt  out : remainder after this iteration
//   root_nxt out : root after this iteration (one more bit appended)
module isqrt_iter_step
  import isqrt_iter_pkg::*;
(
  input  logic [ISQRT_REM_W-1:0] rem,
  input  logic [ISQRT_Y_W-1:0]   root,
  input  logic [1:0]             rad_top,
  output logic [ISQRT_REM_W-1:0] rem_nxt,
  output logic [ISQRT_Y_W-1:0]   root_nxt
);

  logic [ISQRT_REM_W-1:0] r2;
  logic [ISQRT_REM_W-1:0] t;

  // Before any iteration that still matters, rem <= 2*root < 2^16, so the
  // top remainder bits and the root MSB never feed the next step.
  logic step_unused;
  assign step_unused = ^{rem[ISQRT_REM_W-1:ISQRT_Y_W], root[ISQRT_Y_W-1]};

  always_comb begin
    r2       = {rem[ISQRT_Y_W-1:0], rad_top};
    t        = {root, 2'b01};
    rem_nxt  = r2;
    root_nxt = {root[ISQRT_Y_W-2:0], 1'b0};
    if (r2 >= t) begin
      rem_nxt  = r2 - t;
      root_nxt = {root[ISQRT_Y_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/isqrt_iter.sv
// isqrt_iter: iterative unsigned integer square root, y = floor(sqrt(x)),
// one result bit per clock, 17 cycles from request to result strobe.
//   clk    in       : clock, rising edge
//   rst    in       : asynchronous reset, active low
//   x_vld  in       : request strobe
//   x      in  [32] : radicand, sampled when the request is accepted
//   y_vld  out      : one-cycle result strobe
//   y      out [16] : result, held until the next result
//   busy   out      : computation in progress
// Build option ISQRT_ITER_PENDING_EN: one-entry buffer for a request that
// arrives while busy; otherwise such requests are ignored.
module isqrt_iter
  import isqrt_iter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x_vld,
  input  logic [ISQRT_X_W-1:0] x,
  output logic                 y_vld,
  output logic [ISQRT_Y_W-1:0] y,
  output logic                 busy
);

  state_t                 state, state_nxt;
  logic [ISQRT_CNT_W-1:0] iter;
  logic [ISQRT_X_W-1:0]   rad;
  logic [ISQRT_REM_W-1:0] rem, rem_nxt;
  logic [ISQRT_Y_W-1:0]   root, root_nxt;
  logic                   start;
  logic [ISQRT_X_W-1:0]   start_x;

`ifdef ISQRT_ITER_PENDING_EN
  logic                   pend_vld;
  logic [ISQRT_X_W-1:0]   pend_x;
`endif

  isqrt_iter_step u_step (
    .rem      (rem),
    .root     (root),
    .rad_top  (rad[ISQRT_X_W-1:ISQRT_X_W-2]),
    .rem_nxt  (rem_nxt),
    .root_nxt (root_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    start_x   = x;
    case (state)
      ST_IDLE: begin
        if (x_vld) begin
          start     = 1'b1;
          state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        if (iter == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        if (x_vld) begin
          start     = 1'b1;
          state_nxt = ST_CALC;
        end
`ifdef ISQRT_ITER_PENDING_EN
        // A buffered request is older than a fresh one and goes first.
        if (pend_vld) begin
          start     = 1'b1;
          start_x   = pend_x;
          state_nxt = ST_CALC;
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter <= '0;
      rad  <= '0;
      rem  <= '0;
      root <= '0;
      y    <= '0;
    end else if (start) begin
      iter <= ISQRT_CNT_W'(ISQRT_ITERS - 1);
      rad  <= start_x;
      rem  <= '0;
      root <= '0;
    end else if (state == ST_CALC) begin
      rad  <= rad << 2;
      rem  <= rem_nxt;
      root <= root_nxt;
      if (iter == '0) y    <= root_nxt;
      else            iter <= iter - 1'b1;
    end
  end

`ifdef ISQRT_ITER_PENDING_EN
  // Captured while iterating; in the result cycle the slot is drained and,
  // if a new request is present at the same time, refilled with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld <= 1'b0;
      pend_x   <= '0;
    end else if (state == ST_CALC) begin
      if (x_vld && !pend_vld) begin
        pend_vld <= 1'b1;
        pend_x   <= x;
      end
    end else if (state == ST_DONE && pend_vld) begin
      pend_vld <= x_vld;
      if (x_vld) pend_x <= x;
    end
  end
`endif

  assign y_vld = (state == ST_DONE);
  assign busy  = (state == ST_CALC);

endmodule
